dds_fm_sequencer: RTL and testbench
===================================

// Module: dds_fm_sequencer
// PURPOSE
//  Square-wave frequency-modulation scheduler for the triangle-wave DDS. Alternates the DDS tuning word
//  between center-dev (low side) and center+dev (high side), blanks each half-period for a settle time,
//  flags valid sampling windows for the downstream lock-in demodulator, and soft-ramps DDS amplitude
//  on start/stop. Sits between the servo/VIO config sources and the DDS frequency/amp/offset inputs.
// PARAMETERS
//  FREQ_W   32  width of tuning word, center_freq, freq_dev
//  AMP_W    16  width of amplitude and DC offset
//  CNT_W    16  width of dwell/settle counters
//  AMP_STEP 16  amplitude increment/decrement per clock during ramps
// PORTS
//  clk            in   1       system clock
//  rst            in   1       synchronous reset, active-high
//  start          in   1       pulse: begin modulation (honoured in IDLE only)
//  stop           in   1       pulse: end modulation gracefully
//  cfg_valid      in   1       config transfer request
//  cfg_ready      out  1       shadow register empty, config accepted when valid&ready
//  center_freq    in   FREQ_W  modulation center tuning word
//  freq_dev       in   FREQ_W  deviation tuning word
//  dwell_cycles   in   CNT_W   sampling cycles per half-period (0 treated as 1)
//  settle_cycles  in   CNT_W   blanking cycles after each switch (0 = no settle)
//  amp_target     in   AMP_W   final DDS amplitude; dc_offset in AMP_W passed through on cfg transfer
//  dds_freq_word  out  FREQ_W  to DDS frequency input
//  dds_amp        out  AMP_W   to DDS amplitude input
//  dds_dc_offset  out  AMP_W   to DDS DC offset input
//  mod_phase      out  1       0 = low side, 1 = high side
//  sample_valid   out  1       high during DWELL states only
//  period_done    out  1       1-cycle pulse on last cycle of HIGH_DWELL
//  busy           out  1       high in every state except IDLE
// BEHAVIOUR
//  - All outputs registered. Reset: freq_word=0, amp=0, dc_offset=0, mod_phase=0, sample_valid=0,
//    period_done=0, busy=0, cfg_ready=1, active config and shadow cleared, state=IDLE.
//  - States: IDLE -> RAMP_UP -> LOW_SETTLE -> LOW_DWELL -> HIGH_SETTLE -> HIGH_DWELL -> LOW_SETTLE ...
//    -> RAMP_DOWN -> IDLE. SETTLE states skipped when settle_cycles=0.
//  - SETTLE lasts settle_cycles clocks, DWELL lasts max(dwell_cycles,1) clocks; counters reload on entry.
//  - Tuning word: low = center-dev saturating at 0; high = center+dev saturating at 2^FREQ_W-1.
//    dds_freq_word updates on the same edge the state enters LOW_/HIGH_SETTLE (or DWELL if no settle).
//  - RAMP_UP: freq_word = center; amp += AMP_STEP per clock, clamped to amp_target; exit on equality.
//    RAMP_DOWN: freq_word = center; amp -= AMP_STEP, clamped at 0; exit to IDLE when amp=0.
//  - Config: valid&ready loads shadow, cfg_ready drops next cycle. Shadow commits to active config in
//    IDLE next cycle, otherwise only on entry to LOW_SETTLE/LOW_DWELL (period boundary); cfg_ready rises
//    the cycle after commit. dc_offset output follows active config at commit.
//  - start in IDLE -> RAMP_UP next cycle; start while busy ignored. start&stop same cycle in IDLE: stay IDLE.
//  - stop in RAMP_UP -> RAMP_DOWN immediately from current amp. stop in SETTLE/DWELL latched; sequence
//    completes the current HIGH_DWELL (period_done still pulses) then enters RAMP_DOWN. stop in RAMP_DOWN/IDLE ignored.
//  - amp_target change mid-modulation takes effect on next RAMP_UP only (latched at start).
//  - rst mid-operation: all outputs to reset values next edge, no ramp-down.
// CONFIGURATION
//  DDS_FM_SEQ_PERIOD_CNT_EN defined: adds output period_count [31:0], cleared on reset and on start,
//  incremented with each period_done, wraps 2^32-1 -> 0. Undefined: port and counter absent, all
//  other behaviour identical.
// TESTING
//  - rst high 5 cycles -> all outputs at reset values, cfg_ready=1, busy=0.
//  - cfg center=800000 dev=1000 dwell=4 settle=2 amp_target=64 AMP_STEP=16, start -> amp 16,32,48,64 over
//    4 clocks; then freq 799000 for 6 clocks (sample_valid only last 4), 801000 for 6, period_done
//    on 12th cycle, repeating.
//  - center=500 dev=1000 -> low word 0 (saturate); center=2^32-100 dev=1000 -> high word 2^32-1.
//  - mid LOW_DWELL new cfg center=900000 -> cfg_ready low until next LOW_SETTLE entry, then low word
//    899000; current period finishes at old values.
//  - stop during LOW_SETTLE -> HIGH_DWELL completes, period_done pulses, amp 64->0 in 4 clocks, busy drops.
//  - settle=0, dwell=0 -> freq toggles every cycle, sample_valid constantly 1; stop during RAMP_UP at amp=32 -> ramps down 32,16,0.

Source files
------------

// File: rtl/dds_fm_sequencer.sv
// Square-wave FM scheduler for the triangle DDS: alternates center-/+dev, blanks settle time,
// flags lock-in sample windows and soft-ramps amplitude on start/stop.
// Ports: clk, rst (sync, active-high), start/stop pulses, cfg_valid/cfg_ready config handshake,
//   center_freq, freq_dev, dwell_cycles, settle_cycles, amp_target, dc_offset config inputs;
//   dds_freq_word, dds_amp, dds_dc_offset to DDS; mod_phase, sample_valid, period_done, busy status.
// Optional: define DDS_FM_SEQ_PERIOD_CNT_EN to add period_count[31:0] (periods since start).
module dds_fm_sequencer #(
    parameter int FREQ_W   = 32,
    parameter int AMP_W    = 16,
    parameter int CNT_W    = 16,
    parameter int AMP_STEP = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [FREQ_W-1:0] center_freq,
    input  logic [FREQ_W-1:0] freq_dev,
    input  logic [CNT_W-1:0]  dwell_cycles,
    input  logic [CNT_W-1:0]  settle_cycles,
    input  logic [AMP_W-1:0]  amp_target,
    input  logic [AMP_W-1:0]  dc_offset,
    output logic [FREQ_W-1:0] dds_freq_word,
    output logic [AMP_W-1:0]  dds_amp,
    output logic [AMP_W-1:0]  dds_dc_offset,
    output logic              mod_phase,
    output logic              sample_valid,
    output logic              period_done,
    output logic              busy
`ifdef DDS_FM_SEQ_PERIOD_CNT_EN
    ,
    output logic [31:0]       period_count
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        RAMP_UP,
        LOW_SETTLE,
        LOW_DWELL,
        HIGH_SETTLE,
        HIGH_DWELL,
        RAMP_DOWN
    } state_t;

    localparam logic [AMP_W-1:0] STEP = AMP_W'(AMP_STEP);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [AMP_W-1:0] amp_tgt, tgt_n;
    logic             stop_pend, stop_pend_n;

    // shadow (written by handshake) and active (used by the sequencer) config
    logic [FREQ_W-1:0] s_center, s_dev, a_center, a_dev;
    logic [CNT_W-1:0]  s_dwell, s_settle, a_dwell, a_settle;
    logic [AMP_W-1:0]  s_amp, s_dc, a_amp;

    // config as seen after a possible commit on this edge
    logic [FREQ_W-1:0] n_center, n_dev;
    logic [CNT_W-1:0]  n_dwell, n_settle, dwell_ld;
    logic [AMP_W-1:0]  n_amp;

    logic [FREQ_W:0]   hi_sum;
    logic [FREQ_W-1:0] hi_word, lo_word, freq_n;
    logic [AMP_W:0]    amp_sum;
    logic [AMP_W-1:0]  amp_up, amp_dn, amp_n;
    logic              stop_any, in_seq, enter_low, commit, start_ok;

    always_comb begin
        amp_sum = {1'b0, dds_amp} + {1'b0, STEP};
        amp_up  = (amp_sum >= {1'b0, amp_tgt}) ? amp_tgt
                                                : amp_sum[AMP_W-1:0];
        amp_dn  = (dds_amp > STEP) ? dds_amp - STEP : '0;

        stop_any = stop_pend | stop;
        in_seq   = (state == LOW_SETTLE) || (state == LOW_DWELL) ||
                   (state == HIGH_SETTLE) || (state == HIGH_DWELL);

        // period boundary: the only place a running sequence takes new config
        enter_low = ((state == RAMP_UP) && !stop && (amp_up == amp_tgt)) ||
                    ((state == HIGH_DWELL) && (cnt == '0) && !stop_any);
        commit    = !cfg_ready && ((state == IDLE) || enter_low);

        n_center = commit ? s_center : a_center;
        n_dev    = commit ? s_dev    : a_dev;
        n_dwell  = commit ? s_dwell  : a_dwell;
        n_settle = commit ? s_settle : a_settle;
        n_amp    = commit ? s_amp    : a_amp;

        dwell_ld = (n_dwell == '0) ? '0 : n_dwell - ONE;
        hi_sum   = {1'b0, n_center} + {1'b0, n_dev};
        hi_word  = hi_sum[FREQ_W] ? '1 : hi_sum[FREQ_W-1:0];
        lo_word  = (n_center >= n_dev) ? n_center - n_dev : '0;
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        freq_n   = dds_freq_word;
        amp_n    = dds_amp;
        tgt_n    = amp_tgt;
        start_ok = 1'b0;

        unique case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_n  = RAMP_UP;
                    freq_n   = n_center;
                    amp_n    = '0;
                    tgt_n    = n_amp;
                    start_ok = 1'b1;
                end
            end
            RAMP_UP: begin
                if (stop) begin
                    state_n = RAMP_DOWN;
                end else begin
                    amp_n = amp_up;
                end
            end
            LOW_SETTLE: begin
                if (cnt == '0) begin
                    state_n = LOW_DWELL;
                    cnt_n   = dwell_ld;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            LOW_DWELL: begin
                if (cnt == '0) begin
                    freq_n = hi_word;
                    if (n_settle != '0) begin
                        state_n = HIGH_SETTLE;
                        cnt_n   = n_settle - ONE;
                    end else begin
                        state_n = HIGH_DWELL;
                        cnt_n   = dwell_ld;
                    end
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            HIGH_SETTLE: begin
                if (cnt == '0) begin
                    state_n = HIGH_DWELL;
                    cnt_n   = dwell_ld;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            HIGH_DWELL: begin
                if (cnt == '0) begin
                    if (stop_any) begin
                        state_n = RAMP_DOWN;
                        freq_n  = a_center;
                    end
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            RAMP_DOWN: begin
                amp_n = amp_dn;
                if (amp_dn == '0) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // shared low-side entry from RAMP_UP and the end of HIGH_DWELL
        if (enter_low) begin
            freq_n = lo_word;
            if (n_settle != '0) begin
                state_n = LOW_SETTLE;
                cnt_n   = n_settle - ONE;
            end else begin
                state_n = LOW_DWELL;
                cnt_n   = dwell_ld;
            end
        end

        stop_pend_n = (stop_pend | (stop && in_seq)) &&
                      (state_n != RAMP_DOWN) && (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            amp_tgt       <= '0;
            stop_pend     <= 1'b0;
            dds_freq_word <= '0;
            dds_amp       <= '0;
            dds_dc_offset <= '0;
            mod_phase     <= 1'b0;
            sample_valid  <= 1'b0;
            period_done   <= 1'b0;
            busy          <= 1'b0;
            cfg_ready     <= 1'b1;
            s_center      <= '0;
            s_dev         <= '0;
            s_dwell       <= '0;
            s_settle      <= '0;
            s_amp         <= '0;
            s_dc          <= '0;
            a_center      <= '0;
            a_dev         <= '0;
            a_dwell       <= '0;
            a_settle      <= '0;
            a_amp         <= '0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            amp_tgt       <= tgt_n;
            stop_pend     <= stop_pend_n;
            dds_freq_word <= freq_n;
            dds_amp       <= amp_n;
            mod_phase     <= (state_n == HIGH_SETTLE) ||
                             (state_n == HIGH_DWELL);
            sample_valid  <= (state_n == LOW_DWELL) ||
                             (state_n == HIGH_DWELL);
            period_done   <= (state_n == HIGH_DWELL) && (cnt_n == '0);
            busy          <= (state_n != IDLE);
            if (cfg_valid && cfg_ready) begin
                s_center  <= center_freq;
                s_dev     <= freq_dev;
                s_dwell   <= dwell_cycles;
                s_settle  <= settle_cycles;
                s_amp     <= amp_target;
                s_dc      <= dc_offset;
                cfg_ready <= 1'b0;
            end else if (commit) begin
                a_center      <= s_center;
                a_dev         <= s_dev;
                a_dwell       <= s_dwell;
                a_settle      <= s_settle;
                a_amp         <= s_amp;
                dds_dc_offset <= s_dc;
                cfg_ready     <= 1'b1;
            end
        end
    end

`ifdef DDS_FM_SEQ_PERIOD_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            period_count <= '0;
        end else if (start_ok) begin
            period_count <= '0;
        end else if (period_done) begin
            period_count <= period_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dds_fm_sequencer.sv
// Self-checking bench for dds_fm_sequencer: per-cycle expected output
// records are queued with each stimulus step and popped against the DUT.
module tb_dds_fm_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] center_freq = '0;
    logic [31:0] freq_dev = '0;
    logic [15:0] dwell_cycles = '0;
    logic [15:0] settle_cycles = '0;
    logic [15:0] amp_target = '0;
    logic [15:0] dc_offset = '0;
    logic [31:0] dds_freq_word;
    logic [15:0] dds_amp;
    logic [15:0] dds_dc_offset;
    logic        mod_phase;
    logic        sample_valid;
    logic        period_done;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;
    logic [51:0] exp_q[$];

    localparam logic [31:0] HC = 32'hFFFF_FF9C;

    dds_fm_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .center_freq(center_freq), .freq_dev(freq_dev),
        .dwell_cycles(dwell_cycles), .settle_cycles(settle_cycles),
        .amp_target(amp_target), .dc_offset(dc_offset),
        .dds_freq_word(dds_freq_word), .dds_amp(dds_amp),
        .dds_dc_offset(dds_dc_offset), .mod_phase(mod_phase),
        .sample_valid(sample_valid), .period_done(period_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [51:0] ev(logic [31:0] f, logic [15:0] a,
                                       logic ph, logic sv, logic pd,
                                       logic b);
        return {f, a, ph, sv, pd, b};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(int n);
        logic [51:0] e;
        for (int i = 0; i < n; i++) begin
            step();
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $error("FAIL scoreboard_empty observed=none expected=entry");
            end else begin
                e = exp_q.pop_front();
                chk("trace", {12'd0, dds_freq_word, dds_amp, mod_phase,
                    sample_valid, period_done, busy}, {12'd0, e});
            end
        end
    endtask

    task automatic push_period(logic [31:0] lo, logic [31:0] hi,
                               logic [15:0] a, int st, int dw);
        int d;
        d = (dw == 0) ? 1 : dw;
        for (int i = 0; i < st; i++) exp_q.push_back(ev(lo, a, 0, 0, 0, 1));
        for (int i = 0; i < d; i++) exp_q.push_back(ev(lo, a, 0, 1, 0, 1));
        for (int i = 0; i < st; i++) exp_q.push_back(ev(hi, a, 1, 0, 0, 1));
        for (int i = 0; i < d; i++)
            exp_q.push_back(ev(hi, a, 1, 1, (i == d - 1), 1));
    endtask

    task automatic load_cfg(logic [31:0] c, logic [31:0] d, logic [15:0] dw,
                            logic [15:0] st, logic [15:0] a, logic [15:0] dc);
        center_freq   = c;
        freq_dev      = d;
        dwell_cycles  = dw;
        settle_cycles = st;
        amp_target    = a;
        dc_offset     = dc;
        cfg_valid     = 1'b1;
        step();
        cfg_valid = 1'b0;
        chk("cfg_ready_low", {63'd0, cfg_ready}, 64'd0);
        step();
        chk("cfg_ready_back", {63'd0, cfg_ready}, 64'd1);
        chk("dc_offset", {48'd0, dds_dc_offset}, {48'd0, dc});
    endtask

    initial begin
        // reset
        repeat (5) step();
        chk("rst_vec", {12'd0, dds_freq_word, dds_amp, mod_phase,
            sample_valid, period_done, busy}, 64'd0);
        chk("rst_ready", {63'd0, cfg_ready}, 64'd1);
        chk("rst_dc", {48'd0, dds_dc_offset}, 64'd0);
        rst = 1'b0;

        // nominal modulation, two full periods
        load_cfg(32'd800000, 32'd1000, 16'd4, 16'd2, 16'd64, 16'd123);
        start = 1'b1;
        exp_q.push_back(ev(32'd800000, 16'd0, 0, 0, 0, 1));
        exp_q.push_back(ev(32'd800000, 16'd16, 0, 0, 0, 1));
        exp_q.push_back(ev(32'd800000, 16'd32, 0, 0, 0, 1));
        exp_q.push_back(ev(32'd800000, 16'd48, 0, 0, 0, 1));
        push_period(32'd799000, 32'd801000, 16'd64, 2, 4);
        push_period(32'd799000, 32'd801000, 16'd64, 2, 4);
        run(1);
        start = 1'b0;
        run(27);

        // config change mid LOW_DWELL: current period keeps old words
        push_period(32'd799000, 32'd801000, 16'd64, 2, 4);
        run(3);
        center_freq = 32'd900000;
        cfg_valid   = 1'b1;
        run(1);
        cfg_valid = 1'b0;
        chk("mid_ready_low", {63'd0, cfg_ready}, 64'd0);
        run(8);
        chk("mid_ready_hold", {63'd0, cfg_ready}, 64'd0);

        // new words, stop during LOW_SETTLE, graceful ramp-down
        push_period(32'd899000, 32'd901000, 16'd64, 2, 4);
        exp_q.push_back(ev(32'd900000, 16'd64, 0, 0, 0, 1));
        exp_q.push_back(ev(32'd900000, 16'd48, 0, 0, 0, 1));
        exp_q.push_back(ev(32'd900000, 16'd32, 0, 0, 0, 1));
        exp_q.push_back(ev(32'd900000, 16'd16, 0, 0, 0, 1));
        exp_q.push_back(ev(32'd900000, 16'd0, 0, 0, 0, 0));
        run(1);
        chk("commit_ready", {63'd0, cfg_ready}, 64'd1);
        stop = 1'b1;
        run(1);
        stop = 1'b0;
        run(15);

        // low-side saturation at 0
        load_cfg(32'd500, 32'd1000, 16'd1, 16'd0, 16'd16, 16'd7);
        start = 1'b1;
        exp_q.push_back(ev(32'd500, 16'd0, 0, 0, 0, 1));
        exp_q.push_back(ev(32'd0, 16'd16, 0, 1, 0, 1));
        exp_q.push_back(ev(32'd1500, 16'd16, 1, 1, 1, 1));
        exp_q.push_back(ev(32'd500, 16'd16, 0, 0, 0, 1));
        exp_q.push_back(ev(32'd500, 16'd0, 0, 0, 0, 0));
        run(1);
        start = 1'b0;
        run(1);
        stop = 1'b1;
        run(1);
        stop = 1'b0;
        run(2);

        // high-side saturation, dwell=0 settle=0: toggle every cycle
        load_cfg(HC, 32'd1000, 16'd0, 16'd0, 16'd16, 16'd9);
        start = 1'b1;
        exp_q.push_back(ev(HC, 16'd0, 0, 0, 0, 1));
        push_period(32'hFFFF_FBB4, 32'hFFFF_FFFF, 16'd16, 0, 0);
        push_period(32'hFFFF_FBB4, 32'hFFFF_FFFF, 16'd16, 0, 0);
        exp_q.push_back(ev(HC, 16'd16, 0, 0, 0, 1));
        exp_q.push_back(ev(HC, 16'd0, 0, 0, 0, 0));
        run(1);
        start = 1'b0;
        run(3);
        stop = 1'b1;
        run(1);
        stop = 1'b0;
        run(2);

        // stop during RAMP_UP at amp 32
        load_cfg(HC, 32'd1000, 16'd0, 16'd0, 16'd64, 16'd9);
        start = 1'b1;
        exp_q.push_back(ev(HC, 16'd0, 0, 0, 0, 1));
        exp_q.push_back(ev(HC, 16'd16, 0, 0, 0, 1));
        exp_q.push_back(ev(HC, 16'd32, 0, 0, 0, 1));
        exp_q.push_back(ev(HC, 16'd32, 0, 0, 0, 1));
        exp_q.push_back(ev(HC, 16'd16, 0, 0, 0, 1));
        exp_q.push_back(ev(HC, 16'd0, 0, 0, 0, 0));
        run(1);
        start = 1'b0;
        run(2);
        stop = 1'b1;
        run(1);
        stop = 1'b0;
        run(2);

        // start together with stop in IDLE: stays idle
        start = 1'b1;
        stop  = 1'b1;
        exp_q.push_back(ev(HC, 16'd0, 0, 0, 0, 0));
        run(1);
        stop = 1'b0;

        // reset mid-ramp: immediate return to reset values
        exp_q.push_back(ev(HC, 16'd0, 0, 0, 0, 1));
        exp_q.push_back(ev(HC, 16'd16, 0, 0, 0, 1));
        run(1);
        start = 1'b0;
        run(1);
        rst = 1'b1;
        step();
        chk("midrst_vec", {12'd0, dds_freq_word, dds_amp, mod_phase,
            sample_valid, period_done, busy}, 64'd0);
        chk("midrst_ready", {63'd0, cfg_ready}, 64'd1);
        chk("midrst_dc", {48'd0, dds_dc_offset}, 64'd0);
        rst = 1'b0;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
